// File: rtl/sal_bank_arb_pkg.sv
// -----------------------------------------------------------------------------
// sal_bank_arb_pkg -- shared DDR parameter package for the bank arbiter slice.
//   cmd_e        : command codes carried on cmd_type (ACT/RD/WR/PRE/REF)
//   DEF_*        : default bank count and DDR timing spacings (cycles)
//   CNT_W        : width of the timing spacing counters
//   timing_load  : value loaded into a spacing counter for a spacing of t
// -----------------------------------------------------------------------------
package sal_bank_arb_pkg;

  typedef enum logic [2:0] {
    CMD_ACT = 3'd0,
    CMD_RD  = 3'd1,
    CMD_WR  = 3'd2,
    CMD_PRE = 3'd3,
    CMD_REF = 3'd4
  } cmd_e;

  localparam int DEF_BK_CNT = 4;
  localparam int DEF_T_RRD  = 2;
  localparam int DEF_T_CCD  = 2;
  localparam int DEF_T_WTR  = 3;
  localparam int DEF_T_RTW  = 4;

  localparam int CNT_W = 4;

  // A spacing of t cycles loads t-1: the counter reaches zero exactly t
  // cycles after the grant, so t=1 allows back-to-back commands.
  function automatic logic [CNT_W-1:0] timing_load(input int t);
    return CNT_W'(t - 1);
  endfunction

endpackage

// File: rtl/sal_bank_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// sal_bank_arb_rr_pick -- round-robin picker for one command class.
//   req    [N-1:0]  : eligible requests, bit i = bank i
//   rr_ptr [PW-1:0] : bank where the search starts; wraps N-1 -> 0
//   gnt    [N-1:0]  : one-hot pick (all zero when nothing requested)
//   valid           : at least one request was picked
// -----------------------------------------------------------------------------
module sal_bank_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(rr_ptr) + i) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_bank_arb.sv
// -----------------------------------------------------------------------------
// sal_bank_arb -- DDR command arbiter across BK_CNT banks.
//   clk, rst (sync, active-high)
//   act_req/rd_req/wr_req/pre_req/ref_req [BK_CNT-1:0] : per-bank requests
//   act_gnt/rd_gnt/wr_gnt/pre_gnt/ref_gnt [BK_CNT-1:0] : combinational grants,
//       at most one bit set across all five vectors
//   cmd_valid, cmd_type[2:0], cmd_bank : registered copy of last cycle's grant
// Class priority PRE > RD > WR > ACT > REF; one shared round-robin pointer
// picks the bank inside the winning class. Timing-blocked classes are masked
// before picking, so the grant falls through to a lower class in that cycle.
// -----------------------------------------------------------------------------
module sal_bank_arb
  import sal_bank_arb_pkg::*;
#(
  parameter int BK_CNT = DEF_BK_CNT,
  parameter int T_RRD  = DEF_T_RRD,
  parameter int T_CCD  = DEF_T_CCD,
  parameter int T_WTR  = DEF_T_WTR,
  parameter int T_RTW  = DEF_T_RTW,
  parameter int BW     = (BK_CNT > 1) ? $clog2(BK_CNT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BK_CNT-1:0] act_req,
  input  logic [BK_CNT-1:0] rd_req,
  input  logic [BK_CNT-1:0] wr_req,
  input  logic [BK_CNT-1:0] pre_req,
  input  logic [BK_CNT-1:0] ref_req,
  output logic [BK_CNT-1:0] act_gnt,
  output logic [BK_CNT-1:0] rd_gnt,
  output logic [BK_CNT-1:0] wr_gnt,
  output logic [BK_CNT-1:0] pre_gnt,
  output logic [BK_CNT-1:0] ref_gnt,
  output logic              cmd_valid,
  output logic [2:0]        cmd_type,
  output logic [BW-1:0]     cmd_bank
);

  localparam logic [CNT_W-1:0] RRD_LD = timing_load(T_RRD);
  localparam logic [CNT_W-1:0] CCD_LD = timing_load(T_CCD);
  localparam logic [CNT_W-1:0] WTR_LD = timing_load(T_WTR);
  localparam logic [CNT_W-1:0] RTW_LD = timing_load(T_RTW);

  logic [BW-1:0]    rr_ptr;
  logic [CNT_W-1:0] rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;

  logic act_ok, rd_ok, wr_ok;
  assign act_ok = (rrd_cnt == '0);
  assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
  assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);

  logic [BK_CNT-1:0] pre_pick, rd_pick, wr_pick, act_pick, ref_pick;
  logic              pre_v, rd_v, wr_v, act_v, ref_v;

  sal_bank_arb_rr_pick #(.N(BK_CNT), .PW(BW)) u_pick_pre (
    .req(pre_req), .rr_ptr(rr_ptr), .gnt(pre_pick), .valid(pre_v));
  sal_bank_arb_rr_pick #(.N(BK_CNT), .PW(BW)) u_pick_rd (
    .req(rd_req & {BK_CNT{rd_ok}}), .rr_ptr(rr_ptr), .gnt(rd_pick), .valid(rd_v));
  sal_bank_arb_rr_pick #(.N(BK_CNT), .PW(BW)) u_pick_wr (
    .req(wr_req & {BK_CNT{wr_ok}}), .rr_ptr(rr_ptr), .gnt(wr_pick), .valid(wr_v));
  sal_bank_arb_rr_pick #(.N(BK_CNT), .PW(BW)) u_pick_act (
    .req(act_req & {BK_CNT{act_ok}}), .rr_ptr(rr_ptr), .gnt(act_pick), .valid(act_v));
  sal_bank_arb_rr_pick #(.N(BK_CNT), .PW(BW)) u_pick_ref (
    .req(ref_req), .rr_ptr(rr_ptr), .gnt(ref_pick), .valid(ref_v));

  logic              any_gnt;
  cmd_e              gnt_cmd;
  logic [BK_CNT-1:0] gnt_vec;
  logic [BW-1:0]     gnt_bank;

  // Class selection; reset suppresses every grant in the same cycle.
  always_comb begin
    act_gnt = '0;
    rd_gnt  = '0;
    wr_gnt  = '0;
    pre_gnt = '0;
    ref_gnt = '0;
    any_gnt = 1'b0;
    gnt_cmd = CMD_ACT;
    gnt_vec = '0;
    if (!rst) begin
      any_gnt = 1'b1;
      if (pre_v) begin
        pre_gnt = pre_pick; gnt_vec = pre_pick; gnt_cmd = CMD_PRE;
      end else if (rd_v) begin
        rd_gnt = rd_pick;   gnt_vec = rd_pick;  gnt_cmd = CMD_RD;
      end else if (wr_v) begin
        wr_gnt = wr_pick;   gnt_vec = wr_pick;  gnt_cmd = CMD_WR;
      end else if (act_v) begin
        act_gnt = act_pick; gnt_vec = act_pick; gnt_cmd = CMD_ACT;
      end else if (ref_v) begin
        ref_gnt = ref_pick; gnt_vec = ref_pick; gnt_cmd = CMD_REF;
      end else begin
        any_gnt = 1'b0;
      end
    end
  end

  always_comb begin
    gnt_bank = '0;
    for (int i = 0; i < BK_CNT; i++) begin
      if (gnt_vec[i]) gnt_bank = BW'(i);
    end
  end

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      rrd_cnt   <= '0;
      ccd_cnt   <= '0;
      wtr_cnt   <= '0;
      rtw_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_ACT;
      cmd_bank  <= '0;
    end else begin
      rrd_cnt   <= dec_sat(rrd_cnt);
      ccd_cnt   <= dec_sat(ccd_cnt);
      wtr_cnt   <= dec_sat(wtr_cnt);
      rtw_cnt   <= dec_sat(rtw_cnt);
      cmd_valid <= any_gnt;
      if (any_gnt) begin
        rr_ptr   <= (gnt_bank == BW'(BK_CNT - 1)) ? '0 : gnt_bank + 1'b1;
        cmd_type <= gnt_cmd;
        cmd_bank <= gnt_bank;
        // Loads come after the decrements so they win in the same cycle.
        unique case (gnt_cmd)
          CMD_ACT: rrd_cnt <= RRD_LD;
          CMD_RD: begin
            ccd_cnt <= CCD_LD;
            rtw_cnt <= RTW_LD;
          end
          CMD_WR: begin
            ccd_cnt <= CCD_LD;
            wtr_cnt <= WTR_LD;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
